pulse_stretch_arbiter: RTL and testbench
========================================

# pulse_stretch_arbiter

Round-robin arbiter and sequencer that shares one `pulse_stretcher` instance among NREQ requesters. Each requester posts a 1-cycle request strobe and a 16-bit stretch configuration. The block serialises the requests: it loads the stretcher's `config_reg`, fires a 1-cycle `pulse_reg`, and tracks the stretcher's `pulse_out` until the stretched pulse ends. It then returns per-channel done or timeout-error strobes. It sits directly in front of `pulse_stretcher` in the trigger path.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- CFG_W, 16, width of one configuration word (matches `config_reg`)
- TIMEOUT, 1024, cycles allowed in each wait state before error

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req  in  NREQ  per-channel 1-cycle request strobe
- req_cfg  in  NREQ*CFG_W  channel i configuration in bits [i*CFG_W +: CFG_W]
- grant  out  NREQ  one-hot; the channel currently owning the stretcher
- done  out  NREQ  1-cycle strobe; the granted channel's stretch completed
- err  out  NREQ  1-cycle strobe; the granted channel timed out
- busy  out  1  high in any state other than IDLE
- config_reg  out  CFG_W  to stretcher `config_reg`
- pulse_reg  out  1  to stretcher `pulse_reg`
- pulse_out  in  1  from stretcher `pulse_out`, synchronous to clk

## Operation
- Pending latch: `req[i]` sets `pend[i]`. `pend[i]` clears at the end of channel i's service. If a set and a clear hit the same cycle, the set wins. A repeated `req[i]` while `pend[i]` is set is coalesced (ignored).
- Round-robin pointer `ptr`: the search starts at `ptr`. After channel c is serviced (done or err), `ptr = (c+1) mod NREQ`. Reset value of `ptr` is 0.
- FSM states:
  - IDLE: if any `pend` bit is set, select winner w. Register `grant = 1<<w` and `config_reg = req_cfg[w]`. Go to LOAD.
  - LOAD: one settle cycle. Set `pulse_reg <= 1`. Go to FIRE.
  - FIRE: `pulse_reg` is high for exactly this cycle and returns to 0. Go to WAIT_HI.
  - WAIT_HI: wait for `pulse_out = 1`, then go to WAIT_LO. Timeout goes to FAIL.
  - WAIT_LO: wait for `pulse_out = 0`, then go to FIN. Timeout goes to FAIL.
  - FIN: `done[w] = 1` for 1 cycle. `grant` drops. `pend[w]` clears, `ptr` updates. Go to IDLE.
  - FAIL: `err[w] = 1` for 1 cycle. Otherwise identical to FIN.
- `config_reg` holds its last value after service; it changes only in IDLE when a grant is issued.
- Timeout counter width is clog2(TIMEOUT+1). It clears on entry to WAIT_HI and to WAIT_LO. A timeout fires when the count reaches TIMEOUT while the awaited level is still absent.
- If `pulse_out` is already high on entry to WAIT_HI, the block advances to WAIT_LO on the next cycle.

## Timing
- Reset (`rst = 0`, asynchronous) forces the following immediately, regardless of state:
  - state = IDLE
  - `grant`, `done`, `err`, `busy`, `pulse_reg`, `pend` = 0
  - `config_reg` = 0, `ptr` = 0
- Release of reset is synchronous to the next rising edge.
- Latency, with the strobe `req` at cycle 0:
  - `pend` set at cycle 1
  - `grant` and `config_reg` valid at cycle 2 (LOAD)
  - `pulse_reg` high at cycle 3 only
- `done` is asserted 2 cycles after the first cycle in which `pulse_out` is sampled low in WAIT_LO.
- Minimum gap between consecutive grants: one IDLE cycle after FIN/FAIL.
- `config_reg` is stable for at least 1 cycle before `pulse_reg` rises and throughout the stretch.

## Configuration
- Macro `PS_ARB_TIMEOUT_EN`.
- Defined: the timeout counter and FAIL state are as described above.
- Undefined: no counter. WAIT_HI and WAIT_LO wait indefinitely, and `err` is tied to 0.

## Test plan
Bench setup: NREQ=4, TIMEOUT=64, `PS_ARB_TIMEOUT_EN` defined, and a real `pulse_stretcher` connected unless stated otherwise.
- Single request: `req[1]` strobe with cfg 16'o0007 → `grant = 4'b0010` at cycle 2; `config_reg = 16'o0007`; `pulse_reg` high at cycle 3 only; one `done[1]` strobe after `pulse_out` falls; `busy` low afterwards.
- Round-robin: `req[0]`, `req[2]`, `req[3]` strobed in the same cycle → service order 0, 2, 3. Then `req[0]` and `req[3]` together (`ptr` = 0) → order 0, 3.
- Coalesce and re-arm: `req[2]` strobed twice while pending → one service. `req[2]` strobed in the same cycle as its FIN → a second service follows.
- Timeout: stub `pulse_out` stuck at 0 → `err[w]` after 64 cycles in WAIT_HI, no `done`, next channel serviced. With the macro undefined → FSM stays in WAIT_HI and `err` stays 0.
- Reset mid-stretch: drop `rst` during WAIT_LO → all outputs 0 asynchronously, `pend` cleared. After release, a new `req[3]` → `grant[3]` first, because `ptr` is back to 0 with no other requests pending.

Source files
------------

// File: rtl/pulse_stretch_arbiter_if.sv
// Bundle between the requesters/stretcher environment and pulse_stretch_arbiter.
// slave = arbiter side, master = requesters plus the stretcher's pulse_out.
interface pulse_stretch_arbiter_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned CFG_W = 16
);
   logic [NREQ-1:0]       req;
   logic [NREQ*CFG_W-1:0] req_cfg;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       done;
   logic [NREQ-1:0]       err;
   logic                  busy;
   logic [CFG_W-1:0]      config_reg;
   logic                  pulse_reg;
   logic                  pulse_out;

   modport slave (
      input  req, req_cfg, pulse_out,
      output grant, done, err, busy, config_reg, pulse_reg
   );

   modport master (
      output req, req_cfg, pulse_out,
      input  grant, done, err, busy, config_reg, pulse_reg
   );
endinterface

// File: rtl/pulse_stretch_arbiter.sv
// Round-robin sequencer sharing one pulse_stretcher among NREQ requesters.
// Optional macro PS_ARB_TIMEOUT_EN adds the wait-state timeout counter and FAIL/err path.
module pulse_stretch_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned CFG_W   = 16,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   pulse_stretch_arbiter_if.slave bus
);
   localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_chk
      $error("pulse_stretch_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_FIRE, S_WAIT_HI, S_WAIT_LO, S_FIN, S_FAIL
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [NREQ-1:0]  r_pend, w_pend_nxt;
   logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
   logic [PTR_W-1:0] r_win, w_win_nxt;
   logic [NREQ-1:0]  r_grant, w_grant_nxt;
   logic [NREQ-1:0]  r_done, w_done_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_pulse_reg, w_pulse_reg_nxt;
   logic [CFG_W-1:0] r_cfg, w_cfg_nxt;
   logic             w_found;
   logic [PTR_W-1:0] w_sel;
   logic [PTR_W-1:0] w_cand;
   logic             w_tmo;

`ifdef PS_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [NREQ-1:0]  r_err, w_err_nxt;

   assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));

   // Counter runs only while staying in a wait state; any entry restarts it at zero.
   always_comb begin
      w_cnt_nxt = '0;
      if ((r_state == S_WAIT_HI && w_state_nxt == S_WAIT_HI) ||
          (r_state == S_WAIT_LO && w_state_nxt == S_WAIT_LO)) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
         r_err <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_err <= w_err_nxt;
      end
   end

   assign bus.err = r_err;
`else
   assign w_tmo   = 1'b0;
   assign bus.err = '0;
`endif

   // First pending channel at or after the round-robin pointer.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_cand  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_cand = PTR_W'((32'(r_ptr) + k) % NREQ);
         if (!w_found && r_pend[w_cand]) begin
            w_found = 1'b1;
            w_sel   = w_cand;
         end
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pend_nxt      = r_pend;
      w_ptr_nxt       = r_ptr;
      w_win_nxt       = r_win;
      w_grant_nxt     = r_grant;
      w_done_nxt      = '0;
      w_pulse_reg_nxt = 1'b0;
      w_cfg_nxt       = r_cfg;
`ifdef PS_ARB_TIMEOUT_EN
      w_err_nxt       = '0;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_win_nxt   = w_sel;
               w_grant_nxt = NREQ'(1) << w_sel;
               w_cfg_nxt   = bus.req_cfg[w_sel*CFG_W +: CFG_W];
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_pulse_reg_nxt = 1'b1;
            w_state_nxt     = S_FIRE;
         end
         S_FIRE:    w_state_nxt = S_WAIT_HI;
         S_WAIT_HI: begin
            if (bus.pulse_out)  w_state_nxt = S_WAIT_LO;
            else if (w_tmo)     w_state_nxt = S_FAIL;
         end
         S_WAIT_LO: begin
            if (!bus.pulse_out) w_state_nxt = S_FIN;
            else if (w_tmo)     w_state_nxt = S_FAIL;
         end
         S_FIN, S_FAIL: begin
            if (r_state == S_FIN) w_done_nxt = r_grant;
`ifdef PS_ARB_TIMEOUT_EN
            else                  w_err_nxt  = r_grant;
`endif
            w_grant_nxt       = '0;
            w_pend_nxt[r_win] = 1'b0;
            w_ptr_nxt         = (r_win == PTR_W'(NREQ - 1)) ? '0 : r_win + PTR_W'(1);
            w_state_nxt       = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // A new strobe beats the end-of-service clear in the same cycle.
      w_pend_nxt = w_pend_nxt | bus.req;
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_pend      <= '0;
         r_ptr       <= '0;
         r_win       <= '0;
         r_grant     <= '0;
         r_done      <= '0;
         r_busy      <= 1'b0;
         r_pulse_reg <= 1'b0;
         r_cfg       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pend      <= w_pend_nxt;
         r_ptr       <= w_ptr_nxt;
         r_win       <= w_win_nxt;
         r_grant     <= w_grant_nxt;
         r_done      <= w_done_nxt;
         r_busy      <= w_busy_nxt;
         r_pulse_reg <= w_pulse_reg_nxt;
         r_cfg       <= w_cfg_nxt;
      end
   end

   assign bus.grant      = r_grant;
   assign bus.done       = r_done;
   assign bus.busy       = r_busy;
   assign bus.pulse_reg  = r_pulse_reg;
   assign bus.config_reg = r_cfg;
endmodule

// File: tb/tb_pulse_stretch_arbiter.sv
// Scoreboard bench for pulse_stretch_arbiter with a behavioural pulse_stretcher stand-in.
// The stretcher raises pulse_out cfg[5:4] cycles after pulse_reg, for cfg[2:0]+1 cycles.
`timescale 1ns/1ps
module tb_pulse_stretch_arbiter;
   localparam int unsigned NREQ    = 4;
   localparam int unsigned CFG_W   = 16;
   localparam int unsigned TIMEOUT = 64;

   typedef struct {
      int          ch;
      bit          is_err;
      logic [15:0] cfg;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pulse_stretch_arbiter_if #(.NREQ(NREQ), .CFG_W(CFG_W)) bus ();

   pulse_stretch_arbiter #(.NREQ(NREQ), .CFG_W(CFG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        exp_q[$];
   int          m_ptr   = 0;
   logic [15:0] cfg_tab [NREQ];
   bit          stuck   = 1'b0;

   // Stretcher stand-in
   int st_cnt, st_w;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_cnt <= 0;
         st_w   <= 0;
      end else if (bus.pulse_reg) begin
         st_cnt <= stuck ? 0 : int'(bus.config_reg[5:4]) + int'(bus.config_reg[2:0]) + 1;
         st_w   <= int'(bus.config_reg[2:0]) + 1;
      end else if (st_cnt != 0) begin
         st_cnt <= st_cnt - 1;
      end
   end
   assign bus.pulse_out = (st_cnt != 0) && (st_cnt <= st_w);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
      n_tests++;
      if (act !== req_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req_v, $time);
      end
   endtask

   // Monitor: every done/err strobe is matched against the head of the scoreboard.
   logic [NREQ-1:0] mon_hit;
   int              mon_ch;
   exp_t            mon_e;
   always @(negedge clk) begin
      if (rst && (bus.done != '0 || bus.err != '0)) begin
         mon_hit = bus.done | bus.err;
         mon_ch  = 0;
         for (int i = 0; i < NREQ; i++) if (mon_hit[i]) mon_ch = i;
         check("strobe_onehot", 32'($countones(mon_hit)), 32'd1);
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_service: got strobe on ch %0d, required none", mon_ch);
         end else begin
            mon_e = exp_q.pop_front();
            check("svc_channel", 32'(mon_ch), 32'(mon_e.ch));
            check("svc_is_err", 32'(bus.err != '0), 32'(mon_e.is_err));
            check("svc_config", 32'(bus.config_reg), 32'(mon_e.cfg));
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_cfg(input int c, input logic [15:0] v);
      cfg_tab[c] = v;
      bus.req_cfg[c*CFG_W +: CFG_W] = v;
   endtask

   task automatic expect_svc(input int c, input bit e);
      exp_q.push_back('{c, e, cfg_tab[c]});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b0;
      bus.req = '0;
      stuck   = 1'b0;
      exp_q.delete();
      m_ptr   = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((exp_q.size() != 0 || bus.busy) && t < 600) begin
         @(negedge clk);
         t++;
      end
      check("drain_in_budget", 32'(t < 600), 32'd1);
      repeat (8) @(negedge clk);
      check("idle_after_drain", 32'(bus.busy), 32'd0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Reference: all strobes land before the first grant, so service order is a
   // plain round-robin walk of the mask starting at the model pointer.
   task automatic batch(input logic [NREQ-1:0] mask, input bit coalesce);
      int last = -1;
      for (int k = 0; k < NREQ; k++) begin
         int c;
         c = (m_ptr + k) % NREQ;
         if (mask[c]) begin
            expect_svc(c, 1'b0);
            last = c;
         end
      end
      if (last >= 0) m_ptr = (last + 1) % NREQ;
      @(negedge clk);
      bus.req = mask;
      @(negedge clk);
      bus.req = coalesce ? mask : '0;
      if (coalesce) begin
         @(negedge clk);
         bus.req = '0;
      end
      wait_idle();
   endtask

   initial begin
      logic [NREQ-1:0] m;
      bit              seen_hi;
      int              t, t_g, t_e;
      bit              acc_err, acc_done;

      bus.req     = '0;
      bus.req_cfg = '0;
      for (int c = 0; c < NREQ; c++) cfg_tab[c] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_pulse_reg", 32'(bus.pulse_reg), 32'd0);
      check("rst_config", 32'(bus.config_reg), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Single request with cycle-accurate latency
      set_cfg(1, 16'o0007);
      expect_svc(1, 1'b0);
      m_ptr = 2;
      @(negedge clk);
      bus.req = 4'b0010;
      @(negedge clk);
      bus.req = '0;
      check("single_c1_grant", 32'(bus.grant), 32'd0);
      check("single_c1_pulse", 32'(bus.pulse_reg), 32'd0);
      @(negedge clk);
      check("single_c2_grant", 32'(bus.grant), 32'b0010);
      check("single_c2_config", 32'(bus.config_reg), 32'o0007);
      check("single_c2_pulse", 32'(bus.pulse_reg), 32'd0);
      check("single_c2_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      check("single_c3_pulse", 32'(bus.pulse_reg), 32'd1);
      @(negedge clk);
      check("single_c4_pulse", 32'(bus.pulse_reg), 32'd0);
      wait_idle();
      check("single_config_hold", 32'(bus.config_reg), 32'o0007);
      check("single_grant_drop", 32'(bus.grant), 32'd0);

      // Round-robin from ptr 0
      do_reset();
      set_cfg(0, 16'h1231);
      set_cfg(2, 16'h4562);
      set_cfg(3, 16'h7893);
      batch(4'b1101, 1'b0);
      set_cfg(0, 16'hA014);
      set_cfg(3, 16'hB025);
      batch(4'b1001, 1'b0);

      // Coalesce: second strobe while pending gives a single service
      set_cfg(2, 16'h0003);
      batch(4'b0100, 1'b1);

      // Re-arm: strobe in the FIN cycle gives a second service
      expect_svc(2, 1'b0);
      m_ptr = 3;
      @(negedge clk);
      bus.req = 4'b0100;
      @(negedge clk);
      bus.req = '0;
      seen_hi = 1'b0;
      t = 0;
      while (t < 200) begin
         @(negedge clk);
         t++;
         if (bus.pulse_out) seen_hi = 1'b1;
         else if (seen_hi) break;
      end
      check("rearm_pulse_seen", 32'(t < 200), 32'd1);
      @(negedge clk);
      bus.req = 4'b0100;
      expect_svc(2, 1'b0);
      @(negedge clk);
      bus.req = '0;
      check("done_two_after_low", 32'(bus.done), 32'b0100);
      wait_idle();

      // Timeout with pulse_out stuck low
      do_reset();
      set_cfg(1, 16'h00C1);
      set_cfg(2, 16'h0012);
      stuck = 1'b1;
`ifdef PS_ARB_TIMEOUT_EN
      expect_svc(1, 1'b1);
      expect_svc(2, 1'b0);
      m_ptr = 3;
      @(negedge clk);
      bus.req = 4'b0110;
      @(negedge clk);
      bus.req = '0;
      t = 1;
      t_g = -1;
      t_e = -1;
      while (t < 300 && t_e < 0) begin
         @(negedge clk);
         t++;
         if (t_g < 0 && bus.grant != '0) t_g = t;
         if (bus.err != '0) t_e = t;
      end
      stuck = 1'b0;
      check("timeout_grant_cycle", 32'(t_g), 32'd2);
      check("timeout_err_latency", 32'(t_e - t_g), 32'(TIMEOUT + 3));
      wait_idle();
`else
      @(negedge clk);
      bus.req = 4'b0010;
      @(negedge clk);
      bus.req = '0;
      acc_err  = 1'b0;
      acc_done = 1'b0;
      repeat (3 * TIMEOUT) begin
         @(negedge clk);
         acc_err  = acc_err  | (bus.err != '0);
         acc_done = acc_done | (bus.done != '0);
      end
      check("notmo_err_zero", 32'(acc_err), 32'd0);
      check("notmo_no_done", 32'(acc_done), 32'd0);
      check("notmo_still_busy", 32'(bus.busy), 32'd1);
      check("notmo_grant_held", 32'(bus.grant), 32'b0010);
`endif

      // Asynchronous reset in WAIT_LO; pending ch2 must be dropped
      do_reset();
      set_cfg(1, 16'h0007);
      set_cfg(2, 16'h0001);
      @(negedge clk);
      bus.req = 4'b0110;
      @(negedge clk);
      bus.req = '0;
      t = 0;
      while (!bus.pulse_out && t < 50) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_grant", 32'(bus.grant), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_config", 32'(bus.config_reg), 32'd0);
      check("arst_pulse_reg", 32'(bus.pulse_reg), 32'd0);
      check("arst_done_err", 32'(bus.done | bus.err), 32'd0);
      exp_q.delete();
      m_ptr = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      set_cfg(3, 16'h5A21);
      expect_svc(3, 1'b0);
      m_ptr = 0;
      @(negedge clk);
      bus.req = 4'b1000;
      @(negedge clk);
      bus.req = '0;
      @(negedge clk);
      check("post_rst_grant3", 32'(bus.grant), 32'b1000);
      wait_idle();

      // Randomised batches
      for (int it = 0; it < 24; it++) begin
         m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int c = 0; c < NREQ; c++) if (m[c]) set_cfg(c, 16'($urandom));
         batch(m, $urandom_range(0, 1) == 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
